// File: rtl/dp_collect.sv
// dp_collect: assembles 5-word SHA-1 digest bursts, tags each complete digest
// with a running sequence index, keeps only distinguished points (top DP_BITS
// of word 0 all zero) and queues them in a FIFO for word-serial readout.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   din        digest word stream (word 0 flagged by din_first)
//   din_first  marks word 0 of a burst; words 1..4 follow on consecutive cycles
//   out_data   readout word (index, w0, w1, w2, w3, w4 per entry)
//   out_valid  out_data valid (FIFO not empty)
//   out_ready  consumer accepts out_data this cycle
//   out_last   marks w4, the final word of an entry
//   seq        complete digests seen since reset (wraps)
//   drops      distinguished digests lost to a full FIFO (saturating)
//   level      FIFO occupancy in entries
module dp_collect #(
  parameter int DP_BITS = 16,
  parameter int DEPTH   = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              din,
  input  logic                     din_first,
  output logic [31:0]              out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic [31:0]              seq,
  output logic [15:0]              drops,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  typedef enum logic {S_IDLE = 1'b0, S_COLLECT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [2:0]    wcnt_q, wcnt_d;
  logic [31:0]   w_q [5];
  logic [31:0]   w_d [5];
  logic          done_q, done_d;

  // Entry layout: [191:160] index, then w0 .. w4 descending.
  logic [191:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;
  logic [2:0]    rd_word_q;
  logic [31:0]   seq_q;
  logic [15:0]   drops_q;

  logic          dp_s, full_s, push_s, drop_s, xfer_s, pop_s;
  logic [191:0]  head_s;

  // Assembler next state: din_first always restarts a burst, aborting any partial one.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    done_d  = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_d[i] = w_q[i];
    end
    if (din_first) begin
      w_d[0]  = din;
      wcnt_d  = 3'd1;
      state_d = S_COLLECT;
    end else if (state_q == S_COLLECT) begin
      for (int i = 1; i < 5; i++) begin
        if (wcnt_q == 3'(i)) begin
          w_d[i] = din;
        end else begin
          w_d[i] = w_q[i];
        end
      end
      if (wcnt_q == 3'd4) begin
        state_d = S_IDLE;
        wcnt_d  = 3'd0;
        done_d  = 1'b1;
      end else begin
        wcnt_d  = wcnt_q + 3'd1;
      end
    end else begin
      state_d = S_IDLE;
    end
  end

  // Assembler state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= 3'd0;
      done_q  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        w_q[i] <= 32'd0;
      end
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      done_q  <= done_d;
      for (int i = 0; i < 5; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  // FIFO control; the full test deliberately ignores a same-cycle pop.
  always_comb begin
    dp_s   = (w_q[0][31 -: DP_BITS] == '0);
    full_s = (level_q == LVL_FULL);
    push_s = done_q && dp_s && !full_s;
    drop_s = done_q && dp_s && full_s;
    xfer_s = (level_q != '0) && out_ready;
    pop_s  = xfer_s && (rd_word_q == 3'd5);
    head_s = mem_q[rd_ptr_q];
  end

  // Counters, FIFO storage, pointers and readout word position.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q     <= 32'd0;
      drops_q   <= 16'd0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      rd_word_q <= 3'd0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 192'd0;
      end
    end else begin
      if (done_q) begin
        seq_q <= seq_q + 32'd1;
      end
      if (drop_s && (drops_q != 16'hFFFF)) begin
        drops_q <= drops_q + 16'd1;
      end
      if (push_s) begin
        mem_q[wr_ptr_q] <= {seq_q, w_q[0], w_q[1], w_q[2], w_q[3], w_q[4]};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (xfer_s) begin
        if (pop_s) begin
          rd_word_q <= 3'd0;
          rd_ptr_q  <= rd_ptr_q + PTR_ONE;
        end else begin
          rd_word_q <= rd_word_q + 3'd1;
        end
      end
      case ({push_s, pop_s})
        2'b10:   level_q <= level_q + LVL_ONE;
        2'b01:   level_q <= level_q - LVL_ONE;
        default: level_q <= level_q;
      endcase
    end
  end

  // Readout word select from the head entry.
  always_comb begin
    case (rd_word_q)
      3'd0:    out_data = head_s[191:160];
      3'd1:    out_data = head_s[159:128];
      3'd2:    out_data = head_s[127:96];
      3'd3:    out_data = head_s[95:64];
      3'd4:    out_data = head_s[63:32];
      3'd5:    out_data = head_s[31:0];
      default: out_data = 32'd0;
    endcase
  end

  assign out_valid = (level_q != '0);
  assign out_last  = out_valid && (rd_word_q == 3'd5);
  assign seq       = seq_q;
  assign drops     = drops_q;
  assign level     = level_q;

endmodule

// File: tb/tb_dp_collect.sv
// tb_dp_collect: randomized self-checking bench for dp_collect. A transaction
// level reference (burst list, expected-entry queue, counters) predicts every
// output after every clock edge.
module tb_dp_collect;

  localparam int DP    = 16;
  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [31:0]   din = 32'd0;
  logic          din_first = 1'b0;
  logic [31:0]   out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          out_last;
  logic [31:0]   seq;
  logic [15:0]   drops;
  logic [LW-1:0] level;

  dp_collect #(.DP_BITS(DP), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .din_first(din_first),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .seq(seq), .drops(drops), .level(level)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef logic [5:0][31:0] entry_t;   // [0]=index, [1..5]=w0..w4
  entry_t      exp_q[$];
  int          rd_pos;
  logic [31:0] m_seq;
  logic [15:0] m_drops;
  logic [31:0] cur [5];
  int          cur_n;
  logic        pend;
  logic [31:0] pend_w [5];
  int          rmode;                  // 0: never ready, 1: always, 2: random

  task automatic model_clear();
    exp_q.delete();
    rd_pos  = 0;
    m_seq   = 32'd0;
    m_drops = 16'd0;
    cur_n   = 0;
    pend    = 1'b0;
  endtask

  task automatic model_edge(input logic [31:0] d, input logic f, input logic r);
    int     pre;
    entry_t e;
    pre = exp_q.size();
    if (pre != 0 && r) begin
      if (rd_pos == 5) begin
        void'(exp_q.pop_front());
        rd_pos = 0;
      end else begin
        rd_pos++;
      end
    end
    if (pend) begin
      pend = 1'b0;
      if ((pend_w[0] >> (32 - DP)) == 32'd0) begin
        if (pre < DEPTH) begin
          e[0] = m_seq;
          for (int i = 0; i < 5; i++) e[i+1] = pend_w[i];
          exp_q.push_back(e);
        end else if (m_drops != 16'hFFFF) begin
          m_drops++;
        end
      end
      m_seq++;
    end
    if (f) begin
      cur[0] = d;
      cur_n  = 1;
    end else if (cur_n > 0) begin
      cur[cur_n] = d;
      cur_n++;
      if (cur_n == 5) begin
        pend   = 1'b1;
        pend_w = cur;
        cur_n  = 0;
      end
    end
  endtask

  task automatic compare_all();
    check("level", 64'(level), 64'(exp_q.size()));
    check("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    check("seq", 64'(seq), 64'(m_seq));
    check("drops", 64'(drops), 64'(m_drops));
    if (exp_q.size() != 0) begin
      check("out_data", 64'(out_data), 64'(exp_q[0][rd_pos]));
      check("out_last", 64'(out_last), 64'(rd_pos == 5));
    end else begin
      check("out_last_idle", 64'(out_last), 64'd0);
    end
  endtask

  task automatic tick(input logic [31:0] d, input logic f);
    logic r;
    case (rmode)
      0:       r = 1'b0;
      1:       r = 1'b1;
      default: r = 1'($urandom_range(1, 0));
    endcase
    din = d; din_first = f; out_ready = r;
    @(posedge clk); #1;
    model_edge(d, f, r);
    compare_all();
  endtask

  task automatic send_burst(input logic [31:0] w0);
    tick(w0, 1'b1);
    for (int i = 1; i < 5; i++) tick($urandom, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick($urandom, 1'b0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_data"}, 64'(out_data), 64'd0);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_last"}, 64'(out_last), 64'd0);
    check({tag, "_seq"}, 64'(seq), 64'd0);
    check({tag, "_drops"}, 64'(drops), 64'd0);
    check({tag, "_level"}, 64'(level), 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; din_first = 1'b0; din = 32'd0; out_ready = 1'b0;
    #1 model_clear();
    check_zero("rst");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] s0;

  initial begin
    model_clear();
    rmode = 1;

    // 1: single distinguished burst, exact words and latency
    do_reset();
    tick(32'h0000ABCD, 1'b1);
    tick(32'd1, 1'b0); tick(32'd2, 1'b0); tick(32'd3, 1'b0); tick(32'd4, 1'b0);
    check("t1_lat1", 64'(out_valid), 64'd0);
    tick(32'd0, 1'b0);
    check("t1_lat2", 64'(out_valid), 64'd1);
    check("t1_idx", 64'(out_data), 64'd0);
    tick(32'd0, 1'b0); check("t1_w0", 64'(out_data), 64'h0000ABCD);
    tick(32'd0, 1'b0); check("t1_w1", 64'(out_data), 64'd1);
    tick(32'd0, 1'b0); tick(32'd0, 1'b0);
    tick(32'd0, 1'b0); check("t1_w4", 64'(out_data), 64'd4);
    check("t1_last", 64'(out_last), 64'd1);
    tick(32'd0, 1'b0);
    check("t1_empty", 64'(out_valid), 64'd0);
    check("t1_seq", 64'(seq), 64'd1);

    // 2: non-distinguished burst (boundary: lowest set bit of top 16)
    send_burst(32'h0001FFFF);
    idle(4);
    check("t2_level", 64'(level), 64'd0);
    check("t2_seq", 64'(seq), 64'd2);
    check("t2_drops", 64'(drops), 64'd0);

    // 3: fill while stalled, one overflow, then drain
    do_reset();
    rmode = 0;
    for (int b = 0; b < 17; b++) begin
      send_burst($urandom & 32'h0000FFFF);
      idle(15);
    end
    check("t3_level", 64'(level), 64'd16);
    check("t3_drops", 64'(drops), 64'd1);
    check("t3_head_idx", 64'(out_data), 64'd0);
    rmode = 1;
    idle(100);
    check("t3_drained", 64'(level), 64'd0);

    // 4: abort after two words
    s0 = seq;
    tick(32'h00000BAD, 1'b1); tick(32'hDEADBEEF, 1'b0);
    send_burst(32'h00001234);
    idle(10);
    check("t4_seq", 64'(seq), 64'(s0 + 32'd1));

    // 5: random stalls, mixed hits, random gaps (pointer wrap)
    rmode = 2;
    for (int b = 0; b < 100; b++) begin
      send_burst($urandom_range(1, 0) ? ($urandom & 32'h0000FFFF) : ($urandom | 32'h00010000));
      idle($urandom_range(8, 0));
    end
    rmode = 1;
    idle(120);
    check("t5_drained", 64'(level), 64'd0);

    // 6: reset mid-burst with 3 entries queued
    rmode = 0;
    for (int b = 0; b < 3; b++) begin
      send_burst($urandom & 32'h0000FFFF);
      idle(3);
    end
    check("t6_level3", 64'(level), 64'd3);
    tick(32'h00000001, 1'b1); tick(32'h00000002, 1'b0);
    #2 rst = 1'b1;
    #1 model_clear();
    check_zero("t6_async");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_zero("t6_held");
    rmode = 1;
    send_burst(32'h000000AA);
    tick(32'd0, 1'b0);
    check("t6_idx0", 64'(out_data), 64'd0);
    idle(10);
    check("t6_seq", 64'(seq), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
